// File: rtl/lsu_stage.sv
// lsu_stage: RV32I load/store stage with single-outstanding bus and valid/ready writeback.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete with wb_err instead of a bus request.
module lsu_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        wb_err
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_t;
  localparam int CW = $clog2(MAX_WAIT + 2);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [1:0] off, off_q;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic ld_q, acc, mem_op, is_b, is_h, mis, tmo, rsp, waiting;
  logic [31:0] sh, ld_val;
  assign in_ready = state == IDLE || (state == DONE && wb_ready);
  assign wb_valid = state == DONE;
  assign acc = in_valid && in_ready;
  assign mem_op = in_load || in_store;
  assign is_b = in_funct3[1:0] == 2'b00;
  assign is_h = in_funct3[1:0] == 2'b01;
  assign off = is_b ? in_alu_res[1:0] : is_h ? {in_alu_res[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = mem_op && (is_h ? in_alu_res[0] : !is_b && |in_alu_res[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign waiting = state == WAIT_GNT || state == WAIT_RSP;
  assign tmo = MAX_WAIT != 0 && cnt == CW'(MAX_WAIT);
  assign rsp = mem_rvalid && (state == WAIT_RSP || mem_gnt);
  assign sh = mem_rdata >> {off_q, 3'b000};
  assign ld_val = f3_q[1:0] == 2'b00 ? {{24{sh[7] & !f3_q[2]}}, sh[7:0]} :
                  f3_q[1:0] == 2'b01 ? {{16{sh[15] & !f3_q[2]}}, sh[15:0]} : mem_rdata;
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: state_d = acc ? (mem_op && !mis ? WAIT_GNT : DONE) :
                            state == DONE && wb_ready ? IDLE : state;
      WAIT_GNT:   state_d = mem_gnt ? (mem_rvalid ? DONE : WAIT_RSP) : tmo ? DONE : WAIT_GNT;
      WAIT_RSP:   state_d = mem_rvalid || tmo ? DONE : WAIT_RSP;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_we <= 1'b0;
      wb_err <= 1'b0;
      off_q <= '0;
      f3_q <= '0;
      ld_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state <= state_d;
      cnt <= waiting && state_d == state ? cnt + 1'b1 : '0;
      if (acc && mem_op && !mis) begin
        mem_req <= 1'b1;
        mem_we <= !in_load;
        mem_addr <= {in_alu_res[31:2], 2'b00};
        mem_be <= is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
        mem_wdata <= is_b ? {4{in_wdata[7:0]}} : is_h ? {2{in_wdata[15:0]}} : in_wdata;
        off_q <= off;
        f3_q <= in_funct3;
        ld_q <= in_load;
        rd_q <= in_rd;
      end else if (acc) begin
        wb_data <= in_alu_res;
        wb_rd <= mis ? 5'd0 : in_rd;
        wb_we <= !mis && in_rd != 5'd0;
        wb_err <= mis;
      end
      if (state == WAIT_GNT && state_d != WAIT_GNT) mem_req <= 1'b0;
      // a timeout completes with an error beat and no register write
      if (waiting && state_d == DONE) begin
        wb_err <= !rsp;
        wb_we <= rsp && ld_q && rd_q != 5'd0;
        wb_rd <= rsp && ld_q ? rd_q : 5'd0;
        wb_data <= rsp && ld_q ? ld_val : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: table vectors, hand sequences and randomized ops against an arithmetic model.
module tb_lsu_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_load = 0, in_store = 0, mem_gnt = 0, mem_rvalid = 0, wb_ready = 0;
  logic [2:0] in_funct3 = 0;
  logic [31:0] in_alu_res = 0, in_wdata = 0, mem_rdata = 0;
  logic [4:0] in_rd = 0;
  logic in_ready, mem_req, mem_we, wb_valid, wb_we, wb_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0] mem_be;
  logic [4:0] wb_rd;
  int checks = 0, errors = 0;

  lsu_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_store(in_store), .in_funct3(in_funct3), .in_alu_res(in_alu_res), .in_wdata(in_wdata),
    .in_rd(in_rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a, wd, rdw;
    logic [4:0] rd;
    int gd, rdl;
    logic e_mem, e_mwe;
    logic [31:0] e_addr;
    logic [3:0] e_be;
    logic [31:0] e_wdata, e_data;
    logic e_we, e_err;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    int sz, off;
    logic [63:0] x;
    sz = v.f3[1:0] == 2'b00 ? 1 : v.f3[1:0] == 2'b01 ? 2 : 4;
    off = sz == 4 ? 0 : (int'(v.a % 4) / sz) * sz;
    v.e_mem = v.ld || v.st;
    v.e_err = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (v.e_mem && v.a % sz != 0) begin
      v.e_mem = 0;
      v.e_err = 1;
    end
`endif
    v.e_mwe = !v.ld;
    v.e_addr = v.a - v.a % 4;
    v.e_be = 4'(((1 << sz) - 1) << off);
    v.e_wdata = sz == 1 ? v.wd[7:0] * 32'h01010101 : sz == 2 ? v.wd[15:0] * 32'h00010001 : v.wd;
    if (!v.e_mem) begin
      v.e_data = v.a;
      v.e_we = !v.e_err && v.rd != 0;
    end else if (v.ld) begin
      x = ({32'd0, v.rdw} >> (8 * off)) % (64'd1 << (8 * sz));
      if (!v.f3[2] && sz < 4 && x[8*sz-1]) x = x - (64'd1 << (8 * sz));
      v.e_data = x[31:0];
      v.e_we = v.rd != 0;
    end else begin
      v.e_data = 0;
      v.e_we = 0;
    end
    return v;
  endfunction

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3;
    in_alu_res = a; in_wdata = wd; in_rd = rd;
  endtask

  task automatic run_op(input vec_t v, input int wbd);
    @(negedge clk);
    drive_op(v.ld, v.st, v.f3, v.a, v.wd, v.rd);
    #1 chk("in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    mem_rdata = v.rdw;
    if (v.e_mem) begin
      for (int i = 0; i <= v.gd; i++) begin
        if (i > 0) @(negedge clk);
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_be", 32'(mem_be), 32'(v.e_be));
        chk("mem_wdata", mem_wdata, v.e_wdata);
        chk("mem_we", 32'(mem_we), 32'(v.e_mwe));
        chk("wb_valid_busy", 32'(wb_valid), 0);
        mem_gnt = i == v.gd;
        mem_rvalid = i == v.gd && v.rdl == 0;
      end
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      if (v.rdl > 0) begin
        chk("req_drop", 32'(mem_req), 0);
        for (int i = 1; i < v.rdl; i++) @(negedge clk);
        mem_rvalid = 1;
        @(negedge clk);
        mem_rvalid = 0;
      end
    end else chk("no_req", 32'(mem_req), 0);
    for (int i = 0; i <= wbd; i++) begin
      if (i > 0) @(negedge clk);
      chk("wb_valid", 32'(wb_valid), 1);
      chk("wb_data", wb_data, v.e_data);
      chk("wb_we", 32'(wb_we), 32'(v.e_we));
      chk("wb_rd", 32'(wb_rd), v.e_we ? 32'(v.rd) : 0);
      chk("wb_err", 32'(wb_err), 32'(v.e_err));
    end
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;
    chk("wb_drain", 32'(wb_valid), 0);
  endtask

  vec_t tab[14];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{0,0,3'd2,32'h12345678,0,0,5'd5,0,0, 0,0,0,4'h0,0,32'h12345678,1,0};
    tab[1]  = '{0,1,3'd0,32'h00001003,32'hAB,0,5'd4,1,1, 1,1,32'h1000,4'b1000,32'hABABABAB,0,0,0};
    tab[2]  = '{1,0,3'd0,32'h00002001,0,32'h0000F300,5'd3,0,1, 1,0,32'h2000,4'b0010,0,32'hFFFFFFF3,1,0};
    tab[3]  = '{1,0,3'd4,32'h00002001,0,32'h0000F300,5'd3,0,0, 1,0,32'h2000,4'b0010,0,32'h000000F3,1,0};
    tab[4]  = '{1,0,3'd5,32'h00002002,0,32'h80010000,5'd6,3,2, 1,0,32'h2000,4'b1100,0,32'h00008001,1,0};
    tab[5]  = '{1,0,3'd1,32'h00002002,0,32'h80010000,5'd6,0,1, 1,0,32'h2000,4'b1100,0,32'hFFFF8001,1,0};
    tab[6]  = '{1,0,3'd2,32'h00003000,0,32'hDEADBEEF,5'd31,1,3, 1,0,32'h3000,4'b1111,0,32'hDEADBEEF,1,0};
    tab[7]  = '{0,1,3'd1,32'h00001002,32'h1234CDEF,0,5'd1,0,1, 1,1,32'h1000,4'b1100,32'hCDEFCDEF,0,0,0};
    tab[8]  = '{0,1,3'd2,32'h00001004,32'h11223344,0,5'd1,2,0, 1,1,32'h1004,4'b1111,32'h11223344,0,0,0};
    tab[9]  = '{1,0,3'd3,32'h00003000,0,32'h80000001,5'd2,0,1, 1,0,32'h3000,4'b1111,0,32'h80000001,1,0};
    tab[10] = '{0,0,3'd0,32'h0000CAFE,0,0,5'd0,0,0, 0,0,0,4'h0,0,32'h0000CAFE,0,0};
    tab[11] = '{1,1,3'd0,32'h00002003,0,32'h80000000,5'd8,0,1, 1,0,32'h2000,4'b1000,0,32'hFFFFFF80,1,0};
`ifdef LSU_MISALIGN_TRAP_EN
    tab[12] = '{1,0,3'd2,32'h00001002,0,32'h13579BDF,5'd9,0,1, 0,0,0,4'h0,0,32'h00001002,0,1};
    tab[13] = '{1,0,3'd5,32'h00002003,0,32'hBEEF0000,5'd9,0,1, 0,0,0,4'h0,0,32'h00002003,0,1};
`else
    tab[12] = '{1,0,3'd2,32'h00001002,0,32'h13579BDF,5'd9,0,1, 1,0,32'h1000,4'b1111,0,32'h13579BDF,1,0};
    tab[13] = '{1,0,3'd5,32'h00002003,0,32'hBEEF0000,5'd9,0,1, 1,0,32'h2000,4'b1100,0,32'h0000BEEF,1,0};
`endif
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_flags", {29'd0, wb_we, wb_err, mem_we}, 0);

    for (int i = 0; i < 14; i++) run_op(tab[i], i % 3);

    // consume and accept in the same cycle
    @(negedge clk);
    drive_op(0, 0, 3'd0, 32'h0000A5A5, 0, 5'd7);
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 32'(wb_valid), 1);
      chk("hold_data", wb_data, 32'h0000A5A5);
      chk("hold_rd", 32'(wb_rd), 7);
    end
    @(negedge clk);
    wb_ready = 1;
    drive_op(0, 0, 3'd0, 32'h00005A5A, 0, 5'd9);
    #1 chk("b2b_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    wb_ready = 0;
    chk("b2b_valid", 32'(wb_valid), 1);
    chk("b2b_data", wb_data, 32'h00005A5A);
    chk("b2b_rd", 32'(wb_rd), 9);
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;

    // grant never arrives
    @(negedge clk);
    drive_op(1, 0, 3'd2, 32'h00005000, 0, 5'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 0;
      chk("tmo_req", 32'(mem_req), 1);
      chk("tmo_pending", 32'(wb_valid), 0);
    end
    @(negedge clk);
    chk("tmo_valid", 32'(wb_valid), 1);
    chk("tmo_err", 32'(wb_err), 1);
    chk("tmo_we", 32'(wb_we), 0);
    chk("tmo_req_low", 32'(mem_req), 0);
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;
    mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    chk("late_rvalid", 32'(wb_valid), 0);

    // reset while waiting for the response
    @(negedge clk);
    drive_op(1, 0, 3'd2, 32'h00004000, 0, 5'd3);
    @(negedge clk);
    in_valid = 0;
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    rst_n = 0;
    #1;
    chk("arst_addr", mem_addr, 0);
    chk("arst_be", 32'(mem_be), 0);
    chk("arst_wb", {30'd0, wb_valid, mem_req}, 0);
    chk("arst_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1;
    mem_rvalid = 1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_rvalid = 0;
    chk("arst_no_wb", 32'(wb_valid), 0);
    chk("arst_idle", 32'(in_ready), 1);

    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 3);
      rv.ld = k == 1 || k == 3;
      rv.st = k == 2 || k == 3;
      rv.f3 = 3'($urandom);
      rv.a = $urandom;
      rv.wd = $urandom;
      rv.rdw = $urandom;
      rv.rd = 5'($urandom);
      rv.gd = $urandom_range(0, 3);
      rv.rdl = $urandom_range(0, 3);
      run_op(model(rv), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage directly downstream of the 32-bit ALU.
- Consumes the ALU result either as a load/store effective address or as a pass-through writeback value.
- Drives a single-outstanding data-memory bus and presents a registered result to the writeback stage over a valid/ready handshake.
- Performs RV32I byte/halfword lane steering, byte enables and load sign/zero extension.

Parameters:
- MAX_WAIT, 15: cycles allowed in WAIT_GNT or WAIT_RSP before a bus timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds an op
- in_ready  out  1  stage can accept an op
- in_load  in  1  op is load
- in_store  in  1  op is store (in_load & in_store both high = load wins)
- in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- in_alu_res  in  32  ALU result (address, or writeback value)
- in_wdata  in  32  store data (rs2)
- in_rd  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response valid (loads and stores both respond)
- mem_rdata  in  32  read word
- wb_valid  out  1  result available
- wb_ready  in  1  writeback consumes
- wb_data  out  32  result
- wb_rd  out  5  destination (0 for stores)
- wb_we  out  1  register write enable (0 for stores/errors)
- wb_err  out  1  misalign or timeout error

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, wb_err=0; any in-flight transaction is abandoned, with no replay.
- in_ready = 1 only in IDLE, or in DONE when wb_ready=1 (a same-cycle consume-and-accept is legal and required).
- FSM:
  - IDLE/DONE accept with in_valid&in_ready. A load or store goes to WAIT_GNT: mem_req=1 and address/be/wdata registered. A non-memory op goes to DONE with wb_data=in_alu_res, wb_we=(in_rd!=0), wb_rd=in_rd; this is 1-cycle latency.
  - WAIT_GNT: mem_req and all bus outputs are held stable until mem_gnt. On mem_gnt, drop mem_req next cycle and go to WAIT_RSP. mem_gnt and mem_rvalid in the same cycle is legal: go straight to DONE.
  - WAIT_RSP: on mem_rvalid, go to DONE and capture the formatted result.
  - DONE: wb_valid=1, all wb_* held until wb_ready. Then go to IDLE, or take a new op the same cycle.
- Best-case load/store latency: accept at cycle 0, mem_req at cycle 1, gnt at cycle 1, rvalid at cycle 2, wb_valid at cycle 3.
- Byte enables, with off = addr[1:0]:
  - B: be = 0001<<off, wdata = {4{wdata[7:0]}}
  - H: be = 0011<<off, wdata = {2{wdata[15:0]}}
  - W: be = 1111
- Load extraction: byte = rdata>>(8*off) [7:0]; half = rdata>>(8*off) [15:0]. B/H sign-extend, BU/HU zero-extend, W unchanged.
- Undefined funct3 (011, 110, 111) is treated as W.
- Stores: wb_we=0, wb_rd=0, wb_data=0; a writeback beat is still produced so the pipeline sees completion.
- Timeout: waiting more than MAX_WAIT cycles in WAIT_GNT or WAIT_RSP deasserts mem_req and goes to DONE with wb_err=1, wb_we=0. A late rvalid arriving in IDLE is ignored.
- mem_rvalid outside WAIT_GNT/WAIT_RSP is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 issues no bus request; the stage goes IDLE to DONE in 1 cycle with wb_err=1, wb_we=0, wb_data=in_alu_res (faulting address).
- Undefined: low address bits beyond the access size are ignored. Halfword uses off={addr[1],0}; word uses off=0. No error is raised.

Test Plan:
- Non-memory op: alu_res=0x12345678, rd=5 -> next cycle wb_valid=1, wb_data=0x12345678, wb_we=1, no mem_req.
- SB: addr=0x1003, wdata=0xAB -> mem_addr=0x1000, be=1000, mem_wdata=0xABABABAB, mem_we=1; wb_we=0.
- LB: addr=0x2001, rdata=0x0000F300 -> wb_data=0xFFFFFFF3. LBU with the same stimulus -> 0x000000F3. LHU at off 2 with rdata=0x80010000 -> 0x00008001.
- Bus stall: gnt held low 3 cycles -> mem_req and address stable throughout. wb_ready low 2 cycles -> wb_* held; then a back-to-back op is accepted the same cycle wb_ready=1.
- Timeout: MAX_WAIT=4, gnt never asserted -> wb_err=1 after 5 wait cycles; mem_req low afterwards.
- Reset: rst_n low during WAIT_RSP -> all outputs 0 immediately; a later rvalid produces no wb_valid. With LSU_MISALIGN_TRAP_EN, LW at 0x1002 -> wb_err=1, no mem_req.
